// File: rtl/dcfir_beam_accumulator.sv
// dcfir_beam_accumulator: frame-sum complex samples, scale/saturate to valid/ready output; DCFIR_ACC_ROUND_EN selects round-half-up
module dcfir_beam_accumulator #(
  parameter int ACC_LEN = 4,
  parameter int ACC_W = 24,
  parameter int SHIFT = 2
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [15:0] din_real,
  input  logic [15:0] din_imag,
  input  logic        din_valid,
  input  logic        frame_start,
  output logic [15:0] dout_real,
  output logic [15:0] dout_imag,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [15:0] frame_cnt,
  output logic        ovf_err
);
  localparam int CW = $clog2(ACC_LEN) + 1;
`ifdef DCFIR_ACC_ROUND_EN
  localparam logic signed [ACC_W:0] RND = (SHIFT > 0) ? (ACC_W+1)'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0) : '0;
`endif
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_r_q, acc_r_d, acc_i_q, acc_i_d, res_r_q, res_r_d, res_i_q, res_i_d;
  logic [ACC_W-1:0] ext_r, ext_i, sum_r, sum_i;
  logic res_v_q, res_v_d, dout_valid_q, dout_valid_d, ovf_q, ovf_d, last, load;
  logic [15:0] dout_r_q, dout_r_d, dout_i_q, dout_i_d, frame_cnt_q, frame_cnt_d;
  function automatic logic [15:0] scale(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W:0] v;
`ifdef DCFIR_ACC_ROUND_EN
    v = {s[ACC_W-1], s} + RND;
`else
    v = {s[ACC_W-1], s};
`endif
    v = v >>> SHIFT;
    return (!v[ACC_W] && |v[ACC_W-1:15]) ? 16'h7fff :
           (v[ACC_W] && !(&v[ACC_W-1:15])) ? 16'h8000 : v[15:0];
  endfunction
  always_comb begin
    ext_r = {{(ACC_W-16){din_real[15]}}, din_real};
    ext_i = {{(ACC_W-16){din_imag[15]}}, din_imag};
    sum_r = acc_r_q + ext_r;
    sum_i = acc_i_q + ext_i;
    last = state_q == ACCUM && cnt_q == CW'(ACC_LEN - 1);
    state_d = state_q;
    cnt_d = cnt_q;
    acc_r_d = acc_r_q;
    acc_i_d = acc_i_q;
    res_v_d = 1'b0;
    res_r_d = res_r_q;
    res_i_d = res_i_q;
    if (frame_start || (din_valid && state_q == IDLE)) begin
      state_d = din_valid ? ACCUM : IDLE;
      cnt_d = din_valid ? CW'(1) : '0;
      acc_r_d = din_valid ? ext_r : '0;
      acc_i_d = din_valid ? ext_i : '0;
    end else if (din_valid) begin
      state_d = last ? IDLE : ACCUM;
      cnt_d = last ? '0 : cnt_q + CW'(1);
      acc_r_d = sum_r;
      acc_i_d = sum_i;
      res_v_d = last;
      res_r_d = last ? sum_r : res_r_q;
      res_i_d = last ? sum_i : res_i_q;
    end
    load = res_v_q && (!dout_valid_q || dout_ready);
    dout_valid_d = load || (dout_valid_q && !dout_ready);
    dout_r_d = load ? scale(res_r_q) : dout_r_q;
    dout_i_d = load ? scale(res_i_q) : dout_i_q;
    frame_cnt_d = frame_cnt_q + 16'(load);
    ovf_d = ovf_q || (res_v_q && dout_valid_q && !dout_ready);
  end
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_r_q <= '0;
      acc_i_q <= '0;
      res_v_q <= 1'b0;
      res_r_q <= '0;
      res_i_q <= '0;
      dout_valid_q <= 1'b0;
      dout_r_q <= '0;
      dout_i_q <= '0;
      frame_cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_r_q <= acc_r_d;
      acc_i_q <= acc_i_d;
      res_v_q <= res_v_d;
      res_r_q <= res_r_d;
      res_i_q <= res_i_d;
      dout_valid_q <= dout_valid_d;
      dout_r_q <= dout_r_d;
      dout_i_q <= dout_i_d;
      frame_cnt_q <= frame_cnt_d;
      ovf_q <= ovf_d;
    end
  end
  assign dout_real = dout_r_q;
  assign dout_imag = dout_i_q;
  assign dout_valid = dout_valid_q;
  assign frame_cnt = frame_cnt_q;
  assign ovf_err = ovf_q;
endmodule

// File: tb/tb_dcfir_beam_accumulator.sv
// tb_dcfir_beam_accumulator: directed scoreboard bench for SHIFT=2 and SHIFT=0 instances
module tb_dcfir_beam_accumulator;
  logic CLK = 1'b0, rst = 1'b1, din_valid = 1'b0, frame_start = 1'b0, dout_ready = 1'b1;
  logic [15:0] din_real = '0, din_imag = '0;
  logic [15:0] dr0, di0, fc0, dr1, di1, fc1;
  logic dv0, ov0, dv1, ov1;
  logic [31:0] q0[$], q1[$];
  int rv[4], iv[4];
  int total = 0, bad = 0;
  always #5 CLK = ~CLK;
  dcfir_beam_accumulator #(.ACC_LEN(4), .ACC_W(24), .SHIFT(2)) u0 (
    .CLK(CLK), .rst(rst), .din_real(din_real), .din_imag(din_imag), .din_valid(din_valid),
    .frame_start(frame_start), .dout_real(dr0), .dout_imag(di0), .dout_valid(dv0),
    .dout_ready(dout_ready), .frame_cnt(fc0), .ovf_err(ov0));
  dcfir_beam_accumulator #(.ACC_LEN(4), .ACC_W(24), .SHIFT(0)) u1 (
    .CLK(CLK), .rst(rst), .din_real(din_real), .din_imag(din_imag), .din_valid(din_valid),
    .frame_start(frame_start), .dout_real(dr1), .dout_imag(di1), .dout_valid(dv1),
    .dout_ready(dout_ready), .frame_cnt(fc1), .ovf_err(ov1));
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", n, act, exp);
    end
  endtask
  always @(negedge CLK) begin : mon0
    logic [31:0] e;
    if (!rst && dv0 && dout_ready) begin
      if (q0.size() == 0) chk("u0_unexpected_output", 1, 0);
      else begin
        e = q0.pop_front();
        chk("u0_real", int'($signed(dr0)), int'($signed(e[31:16])));
        chk("u0_imag", int'($signed(di0)), int'($signed(e[15:0])));
      end
    end
  end
  always @(negedge CLK) begin : mon1
    logic [31:0] e;
    if (!rst && dv1 && dout_ready) begin
      if (q1.size() == 0) chk("u1_unexpected_output", 1, 0);
      else begin
        e = q1.pop_front();
        chk("u1_real", int'($signed(dr1)), int'($signed(e[31:16])));
        chk("u1_imag", int'($signed(di1)), int'($signed(e[15:0])));
      end
    end
  end
  task automatic step(input int r, input int i, input bit v, input bit fs);
    din_real = 16'(r);
    din_imag = 16'(i);
    din_valid = v;
    frame_start = fs;
    @(posedge CLK);
    #1;
    din_valid = 1'b0;
    frame_start = 1'b0;
  endtask
  task automatic frame(input bit fs, input bit gap, input int e0r, input int e0i,
                       input int e1r, input int e1i, input bit push);
    for (int k = 0; k < 4; k++) begin
      if (k == 3 && push) begin
        q0.push_back({16'(e0r), 16'(e0i)});
        q1.push_back({16'(e1r), 16'(e1i)});
      end
      step(rv[k], iv[k], 1'b1, fs && k == 0);
      if (gap) step(0, 0, 1'b0, 1'b0);
    end
  endtask
  initial begin
    repeat (2) @(posedge CLK);
    #1;
    rst = 1'b0;
    @(negedge CLK);
    chk("rst_dout_valid", dv0, 0);
    chk("rst_dout_real", dr0, 0);
    chk("rst_frame_cnt", fc0, 0);
    chk("rst_ovf_err", ov0, 0);
    @(posedge CLK);
    #1;
    rv = '{100, 200, 300, 400};
    iv = '{-100, -100, -100, -100};
    frame(1'b0, 1'b0, 250, -100, 1000, -400, 1'b1);
    @(negedge CLK);
    chk("lat_valid_early", dv0, 0);
    @(negedge CLK);
    chk("lat_valid_on", dv0, 1);
    chk("t1_frame_cnt", fc0, 1);
    @(negedge CLK);
    chk("lat_valid_pulse", dv0, 0);
    @(posedge CLK);
    #1;
    rv = '{1, 2, 1, 2};
    iv = '{-1, -2, -1, -2};
`ifdef DCFIR_ACC_ROUND_EN
    frame(1'b0, 1'b0, 2, -1, 6, -6, 1'b1);
`else
    frame(1'b0, 1'b0, 1, -2, 6, -6, 1'b1);
`endif
    rv = '{32767, 32767, 32767, 32767};
    iv = '{-32768, -32768, -32768, -32768};
    frame(1'b0, 1'b0, 32767, -32768, 32767, -32768, 1'b1);
    step(1000, 1000, 1'b1, 1'b0);
    step(1000, 1000, 1'b1, 1'b0);
    rv = '{7, 7, 7, 7};
    iv = '{-3, -3, -3, -3};
    frame(1'b1, 1'b1, 7, -3, 28, -12, 1'b1);
    repeat (4) step(0, 0, 1'b0, 1'b0);
    chk("t5_frame_cnt", fc0, 4);
    chk("t5_no_err", ov0, 0);
    dout_ready = 1'b0;
    rv = '{4, 8, 12, 16};
    iv = '{0, 0, 0, 0};
    frame(1'b0, 1'b0, 10, 0, 40, 0, 1'b1);
    rv = '{400, 400, 400, 400};
    frame(1'b0, 1'b0, 400, 0, 1600, 0, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    chk("bp_held_real", int'($signed(dr0)), 10);
    chk("bp_held_valid", dv0, 1);
    chk("bp_ovf_u0", ov0, 1);
    chk("bp_ovf_u1", ov1, 1);
    chk("bp_frame_cnt", fc0, 5);
    @(posedge CLK);
    #1;
    dout_ready = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("bp_valid_cleared", dv0, 0);
    chk("bp_ovf_sticky", ov0, 1);
    @(posedge CLK);
    #1;
    repeat (3) step(5, 5, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge CLK);
    #1;
    rst = 1'b0;
    @(negedge CLK);
    chk("mid_rst_real", dr0, 0);
    chk("mid_rst_imag", di0, 0);
    chk("mid_rst_valid", dv0, 0);
    chk("mid_rst_frame_cnt", fc0, 0);
    chk("mid_rst_ovf", ov0, 0);
    @(posedge CLK);
    #1;
    rv = '{2, 2, 2, 2};
    iv = '{1, 1, 1, 1};
    frame(1'b0, 1'b0, 2, 1, 8, 4, 1'b1);
    repeat (4) step(0, 0, 1'b0, 1'b0);
    chk("post_rst_frame_cnt", fc0, 1);
    chk("post_rst_frame_cnt_u1", fc1, 1);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
